coeff_load_ctrl: RTL and testbench
==================================

Name: coeff_load_ctrl

Overview:
- Sequencer that loads the prestep coefficient bank from a valid/ready word stream.
- On start it accepts num coefficients, emits one registered write per word (wen/addr/value) at consecutive addresses from 0, and builds the cges enable mask so that only loaded taps are active.
- Sits between the host/config stream and prestep_module; its outputs connect directly to that module's wen, addr, value and cges inputs.

Parameters:
- BITS, 32, coefficient word width.
- CGES, 49, number of coefficient slots in the bank.
- AW, $clog2(CGES), address width.
- NW, $clog2(CGES+1), width of the num field (range 0..CGES).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- num  input  NW  number of coefficients to load; valid 1..CGES; sampled with start.
- abort  input  1  cancels an in-progress load.
- s_valid  input  1  stream word valid.
- s_data  input  BITS  stream coefficient word.
- s_ready  output  1  controller can accept a word.
- wen  output  1  bank write enable, registered.
- addr  output  AW  bank write address, registered.
- value  output  BITS  bank write data, registered.
- cges  output  CGES  tap enable mask, registered.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; wen=0, addr=0, value=0, cges=0, busy=0, done=0, err=0, s_ready=0, internal counter=0, latched num=0.
- States are IDLE, LOAD and DONE (type state_t).
- IDLE:
  - s_ready=0.
  - start=1 with 1<=num<=CGES: latch num, counter=0, cges cleared to 0, next state LOAD.
  - start=1 with num=0 or num>CGES: err=1 next cycle, stay in IDLE, cges unchanged.
- LOAD:
  - busy=1; s_ready=1 (combinational from state, independent of s_valid).
  - Handshake when s_valid&s_ready. On the next cycle: wen=1, addr=counter, value=s_data, and cges[counter] set.
  - Counter increments on each handshake.
  - No handshake: wen=0; addr and value hold their last values.
  - Final word (handshake with counter==num-1): next state DONE. The final write still appears on the next cycle.
  - start while in LOAD: ignored, err=1 next cycle.
  - abort in LOAD: next state IDLE, cges cleared to 0, no done, no write for that cycle even if s_valid=1 (abort has priority over handshake). Already-written bank contents are left as is.
- DONE:
  - s_ready=0; done=1 for exactly one cycle (this is the cycle that carries the last wen).
  - cges holds the mask of bits 0..num-1 set.
  - Next state IDLE.
  - abort in DONE is ignored.
- Latency:
  - Handshake to wen is 1 cycle.
  - start to first possible s_ready is 1 cycle.
  - With s_valid held high, a load of N words takes N+1 cycles from entering LOAD to done.
- Mask rule: after a completed load, cges = (1<<num)-1; bits >= num are 0. cges persists in IDLE until the next accepted start or an abort.
- Wrap-around: the counter never exceeds num-1; addresses are always < CGES.
- Reset mid-load: immediate return to the reset state; a partial load leaves cges=0.

Decomposition:
- Shared package coeff_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  - constants COEFF_BITS=32 and COEFF_CGES=49, which are also used by prestep_module instantiations.
- No sub-module; the counter and mask update stay inline.
- Integration: a top-level wrapper instantiates coeff_load_ctrl together with prestep_module.

Test Plan:
- Full load: start, num=49, stream 49 words 0x00000001..0x00000031 with s_valid always high -> 49 wen pulses, addr 0..48 consecutive, value matches each word, done one cycle after the last handshake, cges all ones.
- Partial load with bubbles: num=5, s_valid toggling 1010... -> wen only on cycles following handshakes, addr 0..4, final cges=0x1F, bits 5..48 are 0.
- Illegal commands: start with num=0 -> err pulse, no state change; start with num=50 -> err pulse; start during LOAD -> err pulse, load continues unaffected.
- Abort: num=10, abort after 4 handshakes with s_valid=1 -> exactly 4 writes (addr 0..3), no write for the abort cycle, cges=0, no done, busy=0 on the next cycle.
- Reset mid-load: reset_n low after 3 words -> all outputs 0 immediately. A later load with num=2 then works: addr 0,1 and cges=0x3.
- Back-to-back: start in the cycle after done, with num=3 after a prior num=7 -> cges cleared, then ends at 0x7.

Source files
------------

// File: rtl/coeff_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : coeff_ctrl_pkg
//  Description : Shared types and constants for the prestep coefficient
//                loader and the coefficient bank it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package coeff_ctrl_pkg;

  // Coefficient word width and number of bank slots, shared with prestep_module
  localparam int COEFF_BITS = 32;
  localparam int COEFF_CGES = 49;

  // Loader sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/coeff_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : coeff_load_ctrl
//  Description : Loads the prestep coefficient bank from a valid/ready word
//                stream. Each accepted word becomes one registered bank write
//                at consecutive addresses from 0, and the tap-enable mask is
//                built so that only the loaded taps are active.
//  Revision    : 1.0 - initial release
// ============================================================================
module coeff_load_ctrl
  import coeff_ctrl_pkg::*;
#(
  parameter int BITS = COEFF_BITS,
  parameter int CGES = COEFF_CGES,
  parameter int AW   = $clog2(CGES),
  parameter int NW   = $clog2(CGES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [NW-1:0]   num,
  input  logic            abort,
  input  logic            s_valid,
  input  logic [BITS-1:0] s_data,
  output logic            s_ready,
  output logic            wen,
  output logic [AW-1:0]   addr,
  output logic [BITS-1:0] value,
  output logic [CGES-1:0] cges,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [NW-1:0]   NUM_MAX  = NW'(CGES);
  localparam logic [CGES-1:0] MASK_ONE = CGES'(1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [NW-1:0]   num_q;
  logic            num_ok;
  logic            accept;
  logic            hs;
  logic            last;
  logic            in_idle;
  logic            in_load;

  assign in_idle = (state == IDLE);
  assign in_load = (state == LOAD);

  // A legal request loads between 1 and CGES words
  assign num_ok  = (num != '0) && (num <= NUM_MAX);
  assign accept  = in_idle && start && num_ok;

  // Abort wins over a simultaneous handshake, so it suppresses the write
  assign hs      = in_load && s_valid && !abort;
  assign last    = ((NW'(cnt) + NW'(1)) == num_q);

  // Ready depends only on state so the upstream never sees a valid->ready loop
  assign s_ready = in_load;
  assign busy    = in_load;
  // DONE is the cycle carrying the final registered write
  assign done    = (state == DONE);

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        if (abort)          state_nxt = IDLE;
        else if (hs && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Word counter and latched length; counter wraps to 0 on the final word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      num_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      num_q <= num;
    end else if (in_load && abort) begin
      cnt   <= '0;
    end else if (hs) begin
      cnt   <= last ? '0 : cnt + 1'b1;
    end
  end

  // Bank write port: pulse on the cycle after a handshake, address/data hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wen   <= 1'b0;
      addr  <= '0;
      value <= '0;
    end else begin
      wen <= hs;
      if (hs) begin
        addr  <= cnt;
        value <= s_data;
      end
    end
  end

  // Tap mask: cleared on a new load or abort, one bit added per written slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cges <= '0;
    end else if (accept || (in_load && abort)) begin
      cges <= '0;
    end else if (hs) begin
      cges <= cges | (MASK_ONE << cnt);
    end
  end

  // Illegal command flag: bad length in IDLE or any start while loading
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else          err <= start && ((in_idle && !num_ok) || in_load);
  end

endmodule
`default_nettype wire

// File: tb/tb_coeff_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_coeff_load_ctrl
//  Description : Self-checking bench for coeff_load_ctrl with a transaction
//                level reference model of the coefficient load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coeff_load_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  num;
  logic        abort;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        wen;
  logic [5:0]  addr;
  logic [31:0] value;
  logic [48:0] cges;
  logic        busy;
  logic        done;
  logic        err;

  coeff_load_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .num     (num),
    .abort   (abort),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .wen     (wen),
    .addr    (addr),
    .value   (value),
    .cges    (cges),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  string phase = "reset";

  // Reference model: a load is "active" with a target length and a count of
  // accepted words; the mask is always (2^words)-1 of the words written so far.
  bit          m_load;
  bit          m_donephase;
  int          m_target;
  int          m_words;
  int          m_addr;
  logic [31:0] m_val;
  bit          e_wen, e_err, e_done;
  int          n_writes;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int k);
    return (64'd1 << k) - 64'd1;
  endfunction

  task automatic check_all();
    chk("wen",     {63'd0, wen},     {63'd0, e_wen});
    chk("addr",    {58'd0, addr},    64'(m_addr));
    chk("value",   {32'd0, value},   {32'd0, m_val});
    chk("cges",    {15'd0, cges},    mask_of(m_words));
    chk("done",    {63'd0, done},    {63'd0, e_done});
    chk("err",     {63'd0, err},     {63'd0, e_err});
    chk("busy",    {63'd0, busy},    {63'd0, m_load});
    chk("s_ready", {63'd0, s_ready}, {63'd0, m_load});
  endtask

  task automatic model_reset();
    m_load = 0; m_donephase = 0; m_target = 0; m_words = 0;
    m_addr = 0; m_val = '0; e_wen = 0; e_err = 0; e_done = 0;
  endtask

  // One clock: drive inputs, predict outputs after the edge, then compare
  task automatic cycle(input bit st, input int n, input bit ab, input bit v, input logic [31:0] d);
    start = st; num = n[5:0]; abort = ab; s_valid = v; s_data = d;
    e_wen = 0; e_err = 0; e_done = 0;
    if (m_donephase) begin
      m_donephase = 0;
    end else if (m_load) begin
      if (st) e_err = 1;
      if (ab) begin
        m_load = 0; m_words = 0;
      end else if (v) begin
        e_wen = 1; m_addr = m_words; m_val = d; m_words++;
        if (m_words == m_target) begin
          m_load = 0; m_donephase = 1; e_done = 1;
        end
      end
    end else if (st) begin
      if (n >= 1 && n <= 49) begin
        m_load = 1; m_target = n; m_words = 0;
      end else begin
        e_err = 1;
      end
    end
    @(posedge clk); #1;
    if (e_wen) n_writes++;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 32'd0);
  endtask

  task automatic check_zero();
    chk("rst_wen",   {63'd0, wen},   64'd0);
    chk("rst_addr",  {58'd0, addr},  64'd0);
    chk("rst_value", {32'd0, value}, 64'd0);
    chk("rst_cges",  {15'd0, cges},  64'd0);
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_err",   {63'd0, err},   64'd0);
    chk("rst_rdy",   {63'd0, s_ready}, 64'd0);
  endtask

  initial begin
    int guard;
    int n;
    reset_n = 1'b0; start = 0; num = '0; abort = 0; s_valid = 0; s_data = '0;
    model_reset();
    n_writes = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    idle(1);

    // Full load of 49 words 1..49 with valid always high
    phase = "full";
    n_writes = 0;
    cycle(1, 49, 0, 0, 32'd0);
    for (int i = 1; i <= 49; i++) cycle(0, 0, 0, 1, 32'(i));
    chk("full_writes", 64'(n_writes), 64'd49);
    chk("full_mask", {15'd0, cges}, 64'h1_FFFF_FFFF_FFFF);
    idle(2);

    // Partial load with bubbles
    phase = "bubbles";
    n_writes = 0;
    cycle(1, 5, 0, 0, 32'd0);
    guard = 0;
    while ((m_load || m_donephase) && guard < 100) begin
      cycle(0, 0, 0, guard[0] == 1'b0, $urandom);
      guard++;
    end
    chk("bub_writes", 64'(n_writes), 64'd5);
    chk("bub_mask", {15'd0, cges}, 64'h1F);
    idle(1);

    // Illegal commands
    phase = "illegal";
    cycle(1, 0, 0, 0, 32'd0);
    cycle(0, 0, 0, 0, 32'd0);
    cycle(1, 50, 0, 0, 32'd0);
    cycle(0, 0, 0, 0, 32'd0);
    cycle(1, 4, 0, 0, 32'd0);
    cycle(0, 0, 0, 1, $urandom);
    cycle(1, 9, 0, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 32'd0);
    chk("ill_mask", {15'd0, cges}, 64'hF);
    idle(1);

    // Abort after 4 handshakes
    phase = "abort";
    n_writes = 0;
    cycle(1, 10, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 1, 1, $urandom);
    chk("abort_writes", 64'(n_writes), 64'd4);
    chk("abort_mask", {15'd0, cges}, 64'd0);
    idle(2);

    // Reset in the middle of a load
    phase = "midreset";
    cycle(1, 8, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, $urandom);
    reset_n = 1'b0;
    #1;
    check_zero();
    model_reset();
    start = 0; abort = 0; s_valid = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    n_writes = 0;
    cycle(1, 2, 0, 0, 32'd0);
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 32'd0);
    chk("mr_writes", 64'(n_writes), 64'd2);
    chk("mr_mask", {15'd0, cges}, 64'h3);

    // Back-to-back loads: num=7 then num=3 in the cycle after done
    phase = "b2b";
    cycle(1, 7, 0, 0, 32'd0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 32'd0);
    cycle(1, 3, 0, 0, 32'd0);
    chk("b2b_clear", {15'd0, cges}, 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, 32'd0);
    chk("b2b_mask", {15'd0, cges}, 64'h7);

    // Randomized loads with random bubbles, stray starts and rare aborts
    phase = "random";
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 49);
      cycle(1, n, 0, 0, 32'd0);
      guard = 0;
      while ((m_load || m_donephase) && guard < 400) begin
        cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 63),
              ($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom);
        guard++;
      end
      chk("rnd_bound", 64'(guard < 400), 64'd1);
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
